// File: rtl/sys_bus_arbiter_if.sv
// Two-requester shared-bus bundle: requester ports, shared-bus ports and the grant vector.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface sys_bus_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             rq0_wr;
    logic             rq0_rd;
    logic [1:0]       rq0_size;
    logic [WIDTH-1:0] rq0_addr;
    logic [WIDTH-1:0] rq0_wdata;
    logic [WIDTH-1:0] rq0_rdata;
    logic             rq0_error;
    logic             rq0_ack;

    logic             rq1_wr;
    logic             rq1_rd;
    logic [1:0]       rq1_size;
    logic [WIDTH-1:0] rq1_addr;
    logic [WIDTH-1:0] rq1_wdata;
    logic [WIDTH-1:0] rq1_rdata;
    logic             rq1_error;
    logic             rq1_ack;

    logic             bus_wr;
    logic             bus_rd;
    logic [1:0]       bus_size;
    logic [WIDTH-1:0] bus_addr;
    logic [WIDTH-1:0] bus_wdata;
    logic [WIDTH-1:0] bus_rdata;
    logic             bus_error;

    logic [1:0]       grant;

    modport slave (
        input  rq0_wr, rq0_rd, rq0_size, rq0_addr, rq0_wdata,
        output rq0_rdata, rq0_error, rq0_ack,
        input  rq1_wr, rq1_rd, rq1_size, rq1_addr, rq1_wdata,
        output rq1_rdata, rq1_error, rq1_ack,
        output bus_wr, bus_rd, bus_size, bus_addr, bus_wdata,
        input  bus_rdata, bus_error,
        output grant
    );

    modport master (
        output rq0_wr, rq0_rd, rq0_size, rq0_addr, rq0_wdata,
        input  rq0_rdata, rq0_error, rq0_ack,
        output rq1_wr, rq1_rd, rq1_size, rq1_addr, rq1_wdata,
        input  rq1_rdata, rq1_error, rq1_ack,
        input  bus_wr, bus_rd, bus_size, bus_addr, bus_wdata,
        output bus_rdata, bus_error,
        input  grant
    );
endinterface

// File: rtl/sys_bus_arbiter.sv
// Round-robin arbiter funnelling two requesters onto one shared bus, one transaction at a time.
// Each legal transaction takes IDLE -> ISSUE (strobe) -> RESP (ack); misaligned ones skip the bus.
module sys_bus_arbiter #(
    parameter int WIDTH = 32
) (
    input logic               clk,
    input logic               rst,
    sys_bus_arbiter_if.slave  arb
);
    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_t;

    state_t           state;
    logic [1:0]       grant_q;
    logic             last_grant;
    logic [1:0]       ack_q;
    logic             bus_wr_q;
    logic             bus_rd_q;
    logic             write_q;
    logic             illegal_q;
    logic [1:0]       size_q;
    logic [WIDTH-1:0] addr_q;
    logic [WIDTH-1:0] wdata_q;

    logic             act0;
    logic             act1;
    logic             pick1;
    logic             sel_write;
    logic [1:0]       sel_size;
    logic [WIDTH-1:0] sel_addr;
    logic [WIDTH-1:0] sel_wdata;
    logic             sel_illegal;

    // Reserved size or an address not aligned to the transfer size never reaches the bus.
    function automatic logic is_illegal(input logic [1:0] size, input logic [1:0] low);
        return (size == 2'd3) || (size == 2'd1 && low[0]) || (size == 2'd2 && low != 2'b00);
    endfunction

    always_comb begin
        act0        = arb.rq0_wr | arb.rq0_rd;
        act1        = arb.rq1_wr | arb.rq1_rd;
        pick1       = act1 && (!act0 || !last_grant);
        sel_write   = pick1 ? arb.rq1_wr    : arb.rq0_wr;
        sel_size    = pick1 ? arb.rq1_size  : arb.rq0_size;
        sel_addr    = pick1 ? arb.rq1_addr  : arb.rq0_addr;
        sel_wdata   = pick1 ? arb.rq1_wdata : arb.rq0_wdata;
        sel_illegal = is_illegal(sel_size, sel_addr[1:0]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            grant_q    <= 2'b00;
            last_grant <= 1'b1;
            ack_q      <= 2'b00;
            bus_wr_q   <= 1'b0;
            bus_rd_q   <= 1'b0;
            write_q    <= 1'b0;
            illegal_q  <= 1'b0;
            size_q     <= 2'd0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    ack_q <= 2'b00;
                    if (act0 || act1) begin
                        grant_q    <= pick1 ? 2'b10 : 2'b01;
                        last_grant <= pick1;
                        write_q    <= sel_write;
                        illegal_q  <= sel_illegal;
                        size_q     <= sel_size;
                        addr_q     <= sel_addr;
                        wdata_q    <= sel_wdata;
                        if (sel_illegal) begin
                            ack_q <= pick1 ? 2'b10 : 2'b01;
                            state <= RESP;
                        end else begin
                            bus_wr_q <= sel_write;
                            bus_rd_q <= !sel_write;
                            state    <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    bus_wr_q <= 1'b0;
                    bus_rd_q <= 1'b0;
                    ack_q    <= grant_q;
                    state    <= RESP;
                end
                RESP: begin
                    ack_q   <= 2'b00;
                    grant_q <= 2'b00;
                    state   <= IDLE;
                end
                default: begin
                    ack_q    <= 2'b00;
                    grant_q  <= 2'b00;
                    bus_wr_q <= 1'b0;
                    bus_rd_q <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    // Secondary response arrives in the ack cycle itself, so it is steered through unregistered.
    assign arb.rq0_ack   = ack_q[0];
    assign arb.rq1_ack   = ack_q[1];
    assign arb.rq0_error = ack_q[0] & (illegal_q | arb.bus_error);
    assign arb.rq1_error = ack_q[1] & (illegal_q | arb.bus_error);
    assign arb.rq0_rdata = (ack_q[0] && !write_q && !illegal_q) ? arb.bus_rdata : '0;
    assign arb.rq1_rdata = (ack_q[1] && !write_q && !illegal_q) ? arb.bus_rdata : '0;

    assign arb.bus_wr    = bus_wr_q;
    assign arb.bus_rd    = bus_rd_q;
    assign arb.bus_size  = size_q;
    assign arb.bus_addr  = addr_q;
    assign arb.bus_wdata = wdata_q;
    assign arb.grant     = grant_q;
endmodule

// File: tb/tb_sys_bus_arbiter.sv
// Directed bench for sys_bus_arbiter: inputs change and outputs are checked on the falling edge.
module tb_sys_bus_arbiter;
    logic clk;
    logic rst;
    int   testsRun;
    int   testsFailed;

    sys_bus_arbiter_if #(.WIDTH(32)) arb ();

    sys_bus_arbiter #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .arb (arb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
        testsRun++;
        if (got !== expv) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, expv);
        end
    endtask

    task automatic applyStimulus(input int who, input logic wr, input logic rd,
                                 input logic [1:0] size, input logic [31:0] addr,
                                 input logic [31:0] wdata);
        if (who == 0) begin
            arb.rq0_wr = wr;  arb.rq0_rd = rd;  arb.rq0_size = size;
            arb.rq0_addr = addr;  arb.rq0_wdata = wdata;
        end else begin
            arb.rq1_wr = wr;  arb.rq1_rd = rd;  arb.rq1_size = size;
            arb.rq1_addr = addr;  arb.rq1_wdata = wdata;
        end
    endtask

    task automatic nextCycle();
        @(negedge clk);
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        rst = 1'b1;
        applyStimulus(0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        applyStimulus(1, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        arb.bus_rdata = 32'h0;
        arb.bus_error = 1'b0;
        repeat (3) nextCycle();

        checkOutput("reset grant",    {30'd0, arb.grant}, 32'd0);
        checkOutput("reset bus_rd",   {31'd0, arb.bus_rd}, 32'd0);
        checkOutput("reset bus_wr",   {31'd0, arb.bus_wr}, 32'd0);
        checkOutput("reset bus_addr", arb.bus_addr, 32'd0);
        checkOutput("reset acks",     {30'd0, arb.rq1_ack, arb.rq0_ack}, 32'd0);
        checkOutput("reset rq0_rdata", arb.rq0_rdata, 32'd0);

        // Both requesters read continuously from reset: grants alternate starting at 0.
        rst = 1'b0;
        arb.bus_rdata = 32'h1234_5678;
        applyStimulus(0, 1'b0, 1'b1, 2'd2, 32'h100, 32'h0);
        applyStimulus(1, 1'b0, 1'b1, 2'd2, 32'h200, 32'h0);
        for (int c = 1; c <= 11; c++) begin
            int phase;
            int owner;
            logic [1:0] expGrant;
            nextCycle();
            phase    = c % 3;
            owner    = ((c - 1) / 3) % 2;
            expGrant = (phase == 0) ? 2'b00 : ((owner == 1) ? 2'b10 : 2'b01);
            checkOutput($sformatf("rr grant c%0d", c), {30'd0, arb.grant}, {30'd0, expGrant});
            checkOutput($sformatf("rr rq0_ack c%0d", c), {31'd0, arb.rq0_ack},
                        (phase == 2 && owner == 0) ? 32'd1 : 32'd0);
            checkOutput($sformatf("rr rq1_ack c%0d", c), {31'd0, arb.rq1_ack},
                        (phase == 2 && owner == 1) ? 32'd1 : 32'd0);
            if (phase == 1)
                checkOutput($sformatf("rr bus_addr c%0d", c), arb.bus_addr,
                            (owner == 1) ? 32'h200 : 32'h100);
        end
        checkOutput("rr rq1_rdata c11", arb.rq1_rdata, 32'h1234_5678);
        checkOutput("rr rq0_rdata c11", arb.rq0_rdata, 32'h0);
        applyStimulus(0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        applyStimulus(1, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        nextCycle();

        // rq0 word read from 0x100, secondary returns 0xDEADBEEF.
        arb.bus_rdata = 32'hDEAD_BEEF;
        applyStimulus(0, 1'b0, 1'b1, 2'd2, 32'h100, 32'h0);
        nextCycle();
        checkOutput("rd strobe bus_rd", {31'd0, arb.bus_rd}, 32'd1);
        checkOutput("rd strobe bus_wr", {31'd0, arb.bus_wr}, 32'd0);
        checkOutput("rd strobe size",   {30'd0, arb.bus_size}, 32'd2);
        checkOutput("rd strobe addr",   arb.bus_addr, 32'h100);
        checkOutput("rd strobe no ack", {31'd0, arb.rq0_ack}, 32'd0);
        nextCycle();
        checkOutput("rd resp bus_rd",   {31'd0, arb.bus_rd}, 32'd0);
        checkOutput("rd resp rq0_ack",  {31'd0, arb.rq0_ack}, 32'd1);
        checkOutput("rd resp rq0_rdata", arb.rq0_rdata, 32'hDEAD_BEEF);
        checkOutput("rd resp rq0_error", {31'd0, arb.rq0_error}, 32'd0);
        checkOutput("rd resp rq1_ack",  {31'd0, arb.rq1_ack}, 32'd0);
        checkOutput("rd resp rq1_rdata", arb.rq1_rdata, 32'd0);
        applyStimulus(0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        nextCycle();
        checkOutput("rd idle grant",    {30'd0, arb.grant}, 32'd0);
        checkOutput("rd idle rq0_ack",  {31'd0, arb.rq0_ack}, 32'd0);

        // rq1 misaligned half-word write: acked with error after one cycle, no strobe.
        arb.bus_rdata = 32'hCAFE_F00D;
        applyStimulus(1, 1'b1, 1'b0, 2'd1, 32'h103, 32'h77);
        nextCycle();
        checkOutput("ill bus_wr",    {31'd0, arb.bus_wr}, 32'd0);
        checkOutput("ill bus_rd",    {31'd0, arb.bus_rd}, 32'd0);
        checkOutput("ill grant",     {30'd0, arb.grant}, 32'd2);
        checkOutput("ill rq1_ack",   {31'd0, arb.rq1_ack}, 32'd1);
        checkOutput("ill rq1_error", {31'd0, arb.rq1_error}, 32'd1);
        checkOutput("ill rq1_rdata", arb.rq1_rdata, 32'd0);
        checkOutput("ill rq0_error", {31'd0, arb.rq0_error}, 32'd0);
        applyStimulus(1, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        nextCycle();

        // rq0 byte write to 0x20 with a secondary error.
        arb.bus_error = 1'b1;
        applyStimulus(0, 1'b1, 1'b0, 2'd0, 32'h20, 32'hA5);
        nextCycle();
        checkOutput("wr strobe bus_wr", {31'd0, arb.bus_wr}, 32'd1);
        checkOutput("wr strobe bus_rd", {31'd0, arb.bus_rd}, 32'd0);
        checkOutput("wr strobe size",   {30'd0, arb.bus_size}, 32'd0);
        checkOutput("wr strobe addr",   arb.bus_addr, 32'h20);
        checkOutput("wr strobe wdata",  arb.bus_wdata, 32'hA5);
        nextCycle();
        checkOutput("wr resp bus_wr",    {31'd0, arb.bus_wr}, 32'd0);
        checkOutput("wr resp rq0_ack",   {31'd0, arb.rq0_ack}, 32'd1);
        checkOutput("wr resp rq0_error", {31'd0, arb.rq0_error}, 32'd1);
        checkOutput("wr resp rq0_rdata", arb.rq0_rdata, 32'd0);
        applyStimulus(0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        arb.bus_error = 1'b0;
        nextCycle();
        checkOutput("wr idle addr hold", arb.bus_addr, 32'h20);

        // wr and rd together from rq1 is issued as a write.
        applyStimulus(1, 1'b1, 1'b1, 2'd2, 32'h40, 32'h55);
        nextCycle();
        checkOutput("both strobe bus_wr", {31'd0, arb.bus_wr}, 32'd1);
        checkOutput("both strobe bus_rd", {31'd0, arb.bus_rd}, 32'd0);
        nextCycle();
        checkOutput("both resp rq1_ack", {31'd0, arb.rq1_ack}, 32'd1);
        applyStimulus(1, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        nextCycle();

        // Reset during ISSUE aborts; afterwards a simultaneous request goes to rq0.
        applyStimulus(0, 1'b0, 1'b1, 2'd2, 32'h300, 32'h0);
        nextCycle();
        checkOutput("abort pre bus_rd", {31'd0, arb.bus_rd}, 32'd1);
        rst = 1'b1;
        nextCycle();
        checkOutput("abort grant",   {30'd0, arb.grant}, 32'd0);
        checkOutput("abort bus_rd",  {31'd0, arb.bus_rd}, 32'd0);
        checkOutput("abort rq0_ack", {31'd0, arb.rq0_ack}, 32'd0);
        rst = 1'b0;
        applyStimulus(1, 1'b0, 1'b1, 2'd2, 32'h400, 32'h0);
        nextCycle();
        checkOutput("post rst grant", {30'd0, arb.grant}, 32'd1);
        checkOutput("post rst addr",  arb.bus_addr, 32'h300);
        nextCycle();
        checkOutput("post rst rq0_ack", {31'd0, arb.rq0_ack}, 32'd1);
        checkOutput("post rst rq1_ack", {31'd0, arb.rq1_ack}, 32'd0);
        applyStimulus(0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        applyStimulus(1, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        nextCycle();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule

// File: doc/sys_bus_arbiter.md
SYS_BUS_ARBITER -- requirements
Module: sys_bus_arbiter

Interface
REQ-001 Parameter WIDTH SHALL default 32; data and address width of all ports.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 rq0_wr, rq0_rd  input  1 each  requester 0 write / read request, held until ack.
REQ-005 rq0_size  input  2  requester 0 size: 0 byte, 1 half, 2 word, 3 reserved.
REQ-006 rq0_addr, rq0_wdata  input  WIDTH each  requester 0 address / write data.
REQ-007 rq0_rdata  output  WIDTH  requester 0 read data, valid only with rq0_ack.
REQ-008 rq0_error, rq0_ack  output  1 each  requester 0 error flag / single-cycle completion pulse.
REQ-009 rq1_* SHALL mirror REQ-004..REQ-008 for requester 1.
REQ-010 bus_wr, bus_rd  output  1 each  shared-bus write / read strobe.
REQ-011 bus_size  output  2  shared-bus transfer size.
REQ-012 bus_addr, bus_wdata  output  WIDTH each  shared-bus address / write data.
REQ-013 bus_rdata  input  WIDTH  secondary read data, valid in the cycle after the strobe.
REQ-014 bus_error  input  1  secondary error, valid in the cycle after the strobe.
REQ-015 grant  output  2  one-hot owner of the in-flight transaction; 0 when idle.

Function
REQ-016 FSM states SHALL be IDLE, ISSUE and RESP.
REQ-017 A requester is active when its wr or rd is 1; wr=rd=1 SHALL be treated as a write.
REQ-018 IDLE, one active requester: latch its command (op, size, addr, wdata), set grant, go to ISSUE.
REQ-019 IDLE, both active: grant the requester not equal to last_grant (round-robin).
REQ-020 last_grant SHALL update to the granted index when leaving IDLE.
REQ-021 A request is illegal if size=3, size=1 with addr[0]=1, or size=2 with addr[1:0]!=0.
REQ-022 Illegal request: go IDLE->RESP directly, with no bus strobe.
REQ-023 ISSUE: assert exactly one of bus_wr or bus_rd for exactly one cycle, then go to RESP.
REQ-024 bus_addr, bus_size and bus_wdata SHALL come from the command register and hold between transactions.
REQ-025 RESP: pulse ack of the granted requester for one cycle, then go to IDLE and clear grant.
REQ-026 On ack, rdata SHALL equal bus_rdata and error SHALL equal bus_error.
REQ-027 On an illegal-request ack, rdata=0 and error=1.
REQ-028 On a write ack, rdata SHALL be 0.
REQ-029 The non-granted requester SHALL see ack=0, error=0 and rdata=0.
REQ-030 Legal-access latency: request sampled in IDLE at cycle N, strobe at N+1, ack at N+2.
REQ-031 Illegal-access latency: ack at N+1.
REQ-032 Requester inputs SHALL be ignored outside IDLE.
REQ-033 A requester still active in the cycle after its ack SHALL be treated as a new request.
REQ-034 Back-to-back throughput SHALL be one legal transaction per 3 cycles.

Reset
REQ-035 rst SHALL force IDLE, grant=0, last_grant=1, all acks/strobes/errors 0, and command register and rdata outputs 0.
REQ-036 rst asserted in ISSUE or RESP SHALL abort the transaction with no ack; the bus strobe drops on the next edge.
REQ-037 After reset release, the first simultaneous request SHALL be granted to requester 0.

Verification
REQ-038 rq0 read, word, addr 0x100; secondary returns 0xDEADBEEF -> bus_rd high at N+1 only; rq0_ack=1, rq0_rdata=0xDEADBEEF, rq0_error=0 at N+2.
REQ-039 rq0 and rq1 both reading from reset, held continuously -> grants in order 0,1,0,1; acks at cycles 2,5,8,11 after the first request.
REQ-040 rq1 write, half, addr 0x103 -> no bus strobe; rq1_ack=1, rq1_error=1, rq1_rdata=0 at N+1.
REQ-041 rq0 write, byte, addr 0x20, wdata 0xA5, bus_error=1 -> bus_wr one cycle with bus_size=0, bus_addr=0x20; rq0_ack=1, rq0_error=1.
REQ-042 rst asserted during ISSUE -> no ack issued; grant=0 and bus_rd=0 next cycle; a subsequent simultaneous request is granted to requester 0.
